frame_buffer_wr_arbiter: RTL and testbench

//  Owns the single write port of the frame-buffer/tile dual-port BRAM (we/addr_w/din).

---
 rtl/frame_buffer_wr_arbiter.sv | 159 +++++++++++++++
 tb/tb_frame_buffer_wr_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_wr_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buffer_wr_arbiter
//
// Owns the single write port of the frame-buffer/tile BRAM and shares it
// between CPU MMIO pixel writes (one-entry pending buffer) and a hardware
// fill engine (screen clear / rectangle fill). When both sources want the
// port in the same cycle, the grant strictly alternates.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   cpu_wr/addr/data        1-cycle CPU write strobe and payload
//   cpu_ready               1 = pending buffer empty, cpu_wr will be taken
//   fill_start/abort        1-cycle fill control pulses
//   fill_base/len/data      fill parameters, sampled on an accepted start
//   fill_busy               1 while the fill engine is in FILL
//   fill_done               1-cycle pulse after the last fill word is issued
//   we/addr_w/din           registered BRAM write port
// -----------------------------------------------------------------------------
module frame_buffer_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ready,
    input  logic                  fill_start,
    input  logic                  fill_abort,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH:0]   fill_len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din
);

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t                  state, state_nx;

    logic                    cpu_pend;
    logic [ADDR_WIDTH-1:0]   cpu_addr_q;
    logic [DATA_WIDTH-1:0]   cpu_data_q;

    logic [ADDR_WIDTH-1:0]   fill_ptr;
    logic [ADDR_WIDTH:0]     fill_rem;
    logic [DATA_WIDTH-1:0]   fill_val;

    // 1 = the most recent grant went to the fill engine.
    logic                    last_grant_fill;

    logic                    fill_req;
    logic                    grant_cpu;
    logic                    grant_fill;
    logic                    fill_accept;
    logic                    fill_noop;
    logic                    fill_last;

    assign cpu_ready   = ~cpu_pend;
    assign fill_accept = (state == ST_IDLE) && fill_start && (fill_len != '0);
    assign fill_noop   = (state == ST_IDLE) && fill_start && (fill_len == '0);
    assign fill_last   = (fill_rem == (ADDR_WIDTH+1)'(1));

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state <= state_nx;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned
        // (which would infer a latch).
        state_nx = state;
        case (state)
            ST_IDLE: if (fill_accept) state_nx = ST_FILL;
            ST_FILL: begin
                if (fill_abort)                   state_nx = ST_IDLE;
                else if (grant_fill && fill_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        fill_busy = (state == ST_FILL);
        // An abort cycle issues no fill word.
        fill_req  = (state == ST_FILL) && !fill_abort;
    end

    // ---------------------------------------------------------------- arbitration
    // Under contention the source that did not win last time gets the port.
    always_comb begin
        grant_cpu  = cpu_pend && (!fill_req || last_grant_fill);
        grant_fill = fill_req && (!cpu_pend || !last_grant_fill);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_pend        <= 1'b0;
            cpu_addr_q      <= '0;
            cpu_data_q      <= '0;
            fill_ptr        <= '0;
            fill_rem        <= '0;
            fill_val        <= '0;
            fill_done       <= 1'b0;
            last_grant_fill <= 1'b1;
            we              <= 1'b0;
            addr_w          <= '0;
            din             <= '0;
        end else begin
            // Pending buffer: freed on grant; a new strobe is only taken when
            // empty, so a grant and a capture never coincide.
            if (grant_cpu) begin
                cpu_pend <= 1'b0;
            end else if (cpu_wr && !cpu_pend) begin
                cpu_pend   <= 1'b1;
                cpu_addr_q <= cpu_addr;
                cpu_data_q <= cpu_data;
            end

            if (fill_accept) begin
                fill_ptr <= fill_base;
                fill_rem <= fill_len;
                fill_val <= fill_data;
            end else if (grant_fill) begin
                fill_ptr <= fill_ptr + ADDR_WIDTH'(1);   // wraps at top of buffer
                fill_rem <= fill_rem - (ADDR_WIDTH+1)'(1);
            end

            fill_done <= fill_noop || (grant_fill && fill_last);

            if (grant_cpu)       last_grant_fill <= 1'b0;
            else if (grant_fill) last_grant_fill <= 1'b1;

            // Address/data hold their previous values when nothing is granted.
            we <= grant_cpu || grant_fill;
            if (grant_cpu) begin
                addr_w <= cpu_addr_q;
                din    <= cpu_data_q;
            end else if (grant_fill) begin
                addr_w <= fill_ptr;
                din    <= fill_val;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_wr_arbiter
//
// Self-checking bench for frame_buffer_wr_arbiter. Expected BRAM writes are
// pushed to a scoreboard queue when stimulus is driven; a negedge monitor pops
// and compares every write the DUT issues, in order.
// -----------------------------------------------------------------------------
module tb_frame_buffer_wr_arbiter;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ready;
    logic          fill_start;
    logic          fill_abort;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_len;
    logic [DW-1:0] fill_data;
    logic          fill_busy;
    logic          fill_done;
    logic          we;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] din;

    frame_buffer_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .fill_start (fill_start),
        .fill_abort (fill_abort),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .we         (we),
        .addr_w     (addr_w),
        .din        (din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_fill(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] d);
        fill_start = 1'b1;
        fill_base  = b;
        fill_len   = l;
        fill_data  = d;
    endtask

    // Scoreboard monitor: every BRAM write must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (fill_done) done_cnt++;
            if (we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_write_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(addr_w), 32'(e.addr));
                    check("wr_data", 32'(din), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, sent;

        reset      = 1'b1;
        cpu_wr     = 1'b0;
        cpu_addr   = '0;
        cpu_data   = '0;
        fill_start = 1'b0;
        fill_abort = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_data  = '0;

        // ---- power-on reset state
        repeat (2) @(negedge clk);
        check("por_we",        32'(we),        32'd0);
        check("por_addr_w",    32'(addr_w),    32'd0);
        check("por_din",       32'(din),       32'd0);
        check("por_cpu_ready", 32'(cpu_ready), 32'd1);
        check("por_fill_busy", 32'(fill_busy), 32'd0);
        check("por_fill_done", 32'(fill_done), 32'd0);
        reset = 1'b0;

        // ---- 1: reset in the middle of a fill
        @(negedge clk);
        for (int i = 0; i < 10; i++) push(AW'(12'h100 + i), 8'hE1);
        start_fill(12'h100, 13'd64, 8'hE1);
        @(negedge clk);
        fill_start = 1'b0;
        check("t1_busy", 32'(fill_busy), 32'd1);
        repeat (10) @(negedge clk);           // ten words written
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("t1_rst_we",        32'(we),        32'd0);
        check("t1_rst_addr_w",    32'(addr_w),    32'd0);
        check("t1_rst_din",       32'(din),       32'd0);
        check("t1_rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("t1_rst_busy",      32'(fill_busy), 32'd0);
        check("t1_rst_done",      32'(fill_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_no_done",   32'(done_cnt - d0),  32'd0);
        check("t1_sb_empty",  32'(exp_q.size()),   32'd0);
        check("t1_idle",      32'(fill_busy),      32'd0);

        // ---- 2: lone CPU write, two-cycle latency, single cycle
        w0 = wr_cnt;
        push(12'h123, 8'hA5);
        cpu_wr = 1'b1; cpu_addr = 12'h123; cpu_data = 8'hA5;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("t2_we_n1",    32'(we),        32'd0);
        check("t2_ready_n1", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        check("t2_we_n2",    32'(we),        32'd1);
        check("t2_addr_n2",  32'(addr_w),    32'h123);
        check("t2_din_n2",   32'(din),       32'hA5);
        check("t2_ready_n2", 32'(cpu_ready), 32'd1);
        @(negedge clk);
        check("t2_we_n3",    32'(we),        32'd0);
        check("t2_count",    32'(wr_cnt - w0), 32'd1);

        // ---- 3: fill wrapping the top of the buffer
        w0 = wr_cnt; d0 = done_cnt;
        push(12'hFFE, 8'h3C); push(12'hFFF, 8'h3C);
        push(12'h000, 8'h3C); push(12'h001, 8'h3C);
        start_fill(12'hFFE, 13'd4, 8'h3C);
        @(negedge clk);
        fill_start = 1'b0;
        check("t3_busy", 32'(fill_busy), 32'd1);
        check("t3_we0",  32'(we),        32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_we_b2b", 32'(we), 32'd1);
        end
        check("t3_done_last", 32'(fill_done), 32'd1);
        check("t3_busy_last", 32'(fill_busy), 32'd0);
        @(negedge clk);
        check("t3_done_off", 32'(fill_done), 32'd0);
        check("t3_we_off",   32'(we),        32'd0);
        check("t3_count",    32'(wr_cnt - w0),   32'd4);
        check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

        // ---- 4: fill vs. back-to-back CPU writes, strict alternation
        // last grant was the fill, so the CPU wins the first contended cycle.
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            push(AW'(12'h800 + i), DW'(8'hC0 + i));
            push(AW'(12'h200 + i), 8'h5A);
        end
        start_fill(12'h200, 13'd8, 8'h5A);
        cpu_wr = 1'b1; cpu_addr = 12'h800; cpu_data = 8'hC0;
        sent = 1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            fill_start = 1'b0;
            cpu_wr     = 1'b0;
            check("t4_we_pattern", 32'(we), 32'((k >= 2 && k <= 17) ? 1 : 0));
            if (cpu_ready && sent < 8) begin
                cpu_wr   = 1'b1;
                cpu_addr = AW'(12'h800 + sent);
                cpu_data = DW'(8'hC0 + sent);
                sent++;
            end
        end
        check("t4_cpu_sent",  32'(sent),            32'd8);
        check("t4_count",     32'(wr_cnt - w0),     32'd16);
        check("t4_done_cnt",  32'(done_cnt - d0),   32'd1);
        check("t4_sb_empty",  32'(exp_q.size()),    32'd0);

        // ---- 5: abort after five words, then a fresh fill
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 5; i++) push(AW'(12'h400 + i), 8'h99);
        start_fill(12'h400, 13'd16, 8'h99);
        @(negedge clk);
        fill_start = 1'b0;
        repeat (5) @(negedge clk);
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        check("t5_we_abort",   32'(we),        32'd0);
        check("t5_busy_abort", 32'(fill_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_count",   32'(wr_cnt - w0),   32'd5);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        w0 = wr_cnt; d0 = done_cnt;
        push(12'h010, 8'h77); push(12'h011, 8'h77);
        start_fill(12'h010, 13'd2, 8'h77);
        @(negedge clk);
        fill_start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_restart_count", 32'(wr_cnt - w0),   32'd2);
        check("t5_restart_done",  32'(done_cnt - d0), 32'd1);
        check("t5_restart_idle",  32'(fill_busy),     32'd0);

        // ---- 6: zero-length fill, and a CPU strobe while not ready
        w0 = wr_cnt; d0 = done_cnt;
        start_fill(12'h300, 13'd0, 8'hFF);
        @(negedge clk);
        fill_start = 1'b0;
        check("t6_done_on", 32'(fill_done), 32'd1);
        check("t6_busy",    32'(fill_busy), 32'd0);
        check("t6_we",      32'(we),        32'd0);
        @(negedge clk);
        check("t6_done_off", 32'(fill_done), 32'd0);
        check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        push(12'h0AA, 8'h11);
        cpu_wr = 1'b1; cpu_addr = 12'h0AA; cpu_data = 8'h11;
        @(negedge clk);
        check("t6_ready_low", 32'(cpu_ready), 32'd0);
        cpu_addr = 12'h0BB; cpu_data = 8'h22;     // must be dropped
        @(negedge clk);
        cpu_wr = 1'b0;
        check("t6_we_first", 32'(we),     32'd1);
        check("t6_addr",     32'(addr_w), 32'h0AA);
        repeat (4) @(negedge clk);
        check("t6_count",    32'(wr_cnt - w0),   32'd1);
        check("t6_sb_empty", 32'(exp_q.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
